// File: rtl/shk_reg_bank.sv
// Handshake-driven register bank: IDLE -> ACCESS -> RESP, with sync/clear strobe and sticky errors.
// Optional saturating error counter in m_err_reg_info1[WD_ERR_INFO-1:2] under SHK_REG_ERR_CNT_EN.
module shk_reg_bank #(
  parameter int unsigned WD_SHK_DATA  = 16,
  parameter int unsigned WD_SHK_ADDR  = 16,
  parameter int unsigned NB_REG_DEPTH = 16,
  parameter int unsigned WD_ERR_INFO  = 4
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   s_shk_reg_valid,
  input  logic                   s_shk_reg_msync,
  input  logic [WD_SHK_DATA-1:0] s_shk_reg_mdata,
  input  logic [WD_SHK_ADDR-1:0] s_shk_reg_maddr,
  output logic                   s_shk_reg_ready,
  output logic                   s_shk_reg_ssync,
  output logic [WD_SHK_DATA-1:0] s_shk_reg_sdata,
  output logic [WD_SHK_ADDR-1:0] s_shk_reg_saddr,
  output logic [WD_ERR_INFO-1:0] m_err_reg_info1
);

  localparam int unsigned IdxW = (NB_REG_DEPTH > 1) ? $clog2(NB_REG_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                 state_q;
  logic [WD_SHK_ADDR-1:0] addr_q;
  logic [WD_SHK_DATA-1:0] data_q;
  logic [WD_SHK_DATA-1:0] rdata_q;
  logic [WD_SHK_DATA-1:0] bank_q [NB_REG_DEPTH];
  logic                   ready_q;
  logic                   ssync_q;
  logic [WD_SHK_DATA-1:0] sdata_q;
  logic [WD_SHK_ADDR-1:0] saddr_q;
  logic [1:0]             err_q;

  logic [IdxW-1:0] idx;
  logic            is_wr;
  logic            addr_err;
  logic            aerr_ev;
  logic            ovr_ev;

  assign idx   = addr_q[IdxW-1:0];
  assign is_wr = addr_q[WD_SHK_ADDR-1];

  // Any bit between the index field and the write flag marks an out-of-range address.
  always_comb begin
    addr_err = 1'b0;
    for (int unsigned i = IdxW; i < WD_SHK_ADDR - 1; i++) begin
      addr_err = addr_err | addr_q[i];
    end
  end

  assign aerr_ev = (state_q == StAccess) && addr_err;
  assign ovr_ev  = s_shk_reg_valid && (state_q != StIdle);

`ifdef SHK_REG_ERR_CNT_EN
  localparam int unsigned CntW = WD_ERR_INFO - 2;

  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_base;
  logic [CntW:0]   cnt_sum;

  assign cnt_base = s_shk_reg_msync ? '0 : cnt_q;
  assign cnt_sum  = {1'b0, cnt_base} + (CntW + 1)'(aerr_ev) + (CntW + 1)'(ovr_ev);

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_sum[CntW] ? '1 : cnt_sum[CntW-1:0];
    end
  end
`endif

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      ssync_q <= 1'b0;
      sdata_q <= '0;
      saddr_q <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < NB_REG_DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      ready_q <= 1'b0;
      ssync_q <= s_shk_reg_msync;
      if (s_shk_reg_msync) begin
        err_q <= '0;
        for (int unsigned i = 0; i < NB_REG_DEPTH; i++) begin
          bank_q[i] <= '0;
        end
      end
      if (aerr_ev) err_q[0] <= 1'b1;
      if (ovr_ev)  err_q[1] <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (s_shk_reg_valid) begin
            addr_q  <= s_shk_reg_maddr;
            data_q  <= s_shk_reg_mdata;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // Write is issued after the clear loop so it survives a same-cycle msync.
          if (addr_err) begin
            rdata_q <= '0;
          end else if (is_wr) begin
            bank_q[idx] <= data_q;
            rdata_q     <= data_q;
          end else begin
            rdata_q <= bank_q[idx];
          end
          state_q <= StResp;
        end
        StResp: begin
          ready_q <= 1'b1;
          sdata_q <= rdata_q;
          saddr_q <= addr_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    m_err_reg_info1      = '0;
    m_err_reg_info1[1:0] = err_q;
`ifdef SHK_REG_ERR_CNT_EN
    m_err_reg_info1[WD_ERR_INFO-1:2] = cnt_q;
`endif
  end

  assign s_shk_reg_ready = ready_q;
  assign s_shk_reg_ssync = ssync_q;
  assign s_shk_reg_sdata = sdata_q;
  assign s_shk_reg_saddr = saddr_q;

endmodule

// File: tb/tb_shk_reg_bank.sv
// Randomized self-checking bench for shk_reg_bank against an array-based behavioural model.
// Expected error-info upper bits follow SHK_REG_ERR_CNT_EN.
module tb_shk_reg_bank;

  localparam int DW = 16;
  localparam int AW = 16;
  localparam int ND = 16;
  localparam int EW = 4;
  localparam int CntMax = (1 << (EW - 2)) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          msync;
  logic [DW-1:0] mdata;
  logic [AW-1:0] maddr;
  logic          ready;
  logic          ssync;
  logic [DW-1:0] sdata;
  logic [AW-1:0] saddr;
  logic [EW-1:0] info;

  shk_reg_bank #(
    .WD_SHK_DATA (DW),
    .WD_SHK_ADDR (AW),
    .NB_REG_DEPTH(ND),
    .WD_ERR_INFO (EW)
  ) u_dut (
    .i_sys_clk      (clk),
    .i_sys_rst      (rst),
    .s_shk_reg_valid(valid),
    .s_shk_reg_msync(msync),
    .s_shk_reg_mdata(mdata),
    .s_shk_reg_maddr(maddr),
    .s_shk_reg_ready(ready),
    .s_shk_reg_ssync(ssync),
    .s_shk_reg_sdata(sdata),
    .s_shk_reg_saddr(saddr),
    .m_err_reg_info1(info)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int bank_m [ND];
  int err_m;
  int cnt_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] info_m();
`ifdef SHK_REG_ERR_CNT_EN
    return 32'((cnt_m << 2) | err_m);
`else
    return 32'(err_m);
`endif
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ND; i++) bank_m[i] = 0;
    err_m = 0;
    cnt_m = 0;
  endtask

  // One request: optional msync with valid (sync0), extra valid in ACCESS (ovr),
  // or msync during ACCESS (sync1).
  task automatic do_req(input logic [15:0] addr, input logic [15:0] data,
                        input bit sync0, input bit ovr, input bit sync1);
    bit   bad;
    int   idx;
    int   ev;
    logic [15:0] exp;
    bad = (addr[14:4] != 0);
    idx = int'(addr[3:0]);
    valid = 1'b1; maddr = addr; mdata = data; msync = sync0;
    tick();
    if (sync0) model_clear();
    check_eq("ssync_req", 32'(ssync), 32'(sync0));
    check_eq("ready_n0", 32'(ready), 0);
    valid = ovr; maddr = 16'($urandom); mdata = 16'($urandom); msync = sync1;
    tick();
    ev = 0;
    if (bad) exp = 16'h0;
    else if (addr[15]) exp = data;
    else exp = 16'(bank_m[idx]);
    if (sync1) model_clear();
    if (!bad && addr[15]) bank_m[idx] = int'(data);
    if (bad) begin err_m |= 1; ev++; end
    if (ovr) begin err_m |= 2; ev++; end
    cnt_m = (cnt_m + ev > CntMax) ? CntMax : cnt_m + ev;
    valid = 1'b0; msync = 1'b0;
    check_eq("ssync_acc", 32'(ssync), 32'(sync1));
    check_eq("ready_n1", 32'(ready), 0);
    tick();
    check_eq("ready_n2", 32'(ready), 1);
    check_eq("saddr", 32'(saddr), 32'(addr));
    check_eq("sdata", 32'(sdata), 32'(exp));
    tick();
    check_eq("ready_n3", 32'(ready), 0);
    check_eq("sdata_hold", 32'(sdata), 32'(exp));
    check_eq("info", 32'(info), info_m());
  endtask

  task automatic pulse_sync();
    msync = 1'b1;
    tick();
    msync = 1'b0;
    model_clear();
    check_eq("ssync_pulse", 32'(ssync), 1);
    check_eq("info_clr", 32'(info), info_m());
    tick();
    check_eq("ssync_low", 32'(ssync), 0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < ND; i++) begin
      do_req(16'(i), 16'h0, 1'b0, 1'b0, 1'b0);
      check_eq(tag, 32'(sdata), 32'(bank_m[i]));
    end
  endtask

  initial begin
    logic [15:0] a;
    int r;
    bit bad_r;
    bit ovr_r;
    rst = 1'b1; valid = 1'b0; msync = 1'b0; mdata = '0; maddr = '0;
    model_clear();
    tick();
    tick();
    check_eq("rst_ready", 32'(ready), 0);
    check_eq("rst_ssync", 32'(ssync), 0);
    check_eq("rst_sdata", 32'(sdata), 0);
    check_eq("rst_saddr", 32'(saddr), 0);
    check_eq("rst_info", 32'(info), 0);
    rst = 1'b0;
    tick();

    // Write then read back.
    do_req(16'h8003, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    do_req(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("rd_a5a5", 32'(sdata), 32'hA5A5);
    // Bad addresses: read and write, bank unchanged.
    do_req(16'h0013, 16'h0000, 1'b0, 1'b0, 1'b0);
    do_req(16'h8013, 16'h5555, 1'b0, 1'b0, 1'b0);
    do_req(16'h0003, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("bad_no_wr", 32'(sdata), 32'hA5A5);
    // Overrun, then a bad-address+overrun in the same cycle (counter saturates).
    do_req(16'h8004, 16'h1111, 1'b0, 1'b1, 1'b0);
    do_req(16'h0020, 16'h0000, 1'b0, 1'b1, 1'b0);
    // Clear.
    do_req(16'h8005, 16'h1234, 1'b0, 1'b0, 1'b0);
    pulse_sync();
    do_req(16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("clr_rd5", 32'(sdata), 0);
    // Simultaneous valid+msync lands on cleared bank.
    do_req(16'h8007, 16'h7777, 1'b0, 1'b0, 1'b0);
    do_req(16'h8002, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    read_all("bank_after_sync");
    // msync during ACCESS of a write: the write survives.
    do_req(16'h8009, 16'h9999, 1'b0, 1'b0, 1'b0);
    do_req(16'h800A, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    read_all("bank_acc_sync");

    // Reset mid-transaction, with valid held during reset.
    valid = 1'b1; maddr = 16'h8006; mdata = 16'h6666;
    tick();
    rst = 1'b1; maddr = 16'h8008; mdata = 16'h8888;
    tick();
    rst = 1'b0; valid = 1'b0;
    model_clear();
    check_eq("mid_rst_ready", 32'(ready), 0);
    check_eq("mid_rst_info", 32'(info), 0);
    check_eq("mid_rst_saddr", 32'(saddr), 0);
    tick();
    check_eq("mid_rst_ready1", 32'(ready), 0);
    tick();
    check_eq("mid_rst_ready2", 32'(ready), 0);
    do_req(16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_rd6", 32'(sdata), 0);
    do_req(16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("mid_rst_rd8", 32'(sdata), 0);

    // Randomized traffic.
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      a = 16'($urandom_range(0, ND - 1));
      if ($urandom_range(0, 1) == 1) a[15] = 1'b1;
      bad_r = (r == 0);
      if (bad_r) a[4 + $urandom_range(0, 10)] = 1'b1;
      ovr_r = ($urandom_range(0, 7) == 0);
      if (r == 4) pulse_sync();
      do_req(a, 16'($urandom), r == 1, ovr_r, (r == 3) && !bad_r && !ovr_r);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
    end
    read_all("bank_final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shk_reg_bank.md
SHK_REG_BANK -- requirements
Module: shk_reg_bank

Interface
REQ-001 SHALL have parameter WD_SHK_DATA, default 16: shake data width.
REQ-002 SHALL have parameter WD_SHK_ADDR, default 16: shake address width; MSB is the write flag.
REQ-003 SHALL have parameter NB_REG_DEPTH, default 16: register count; power of 2, 2..256.
REQ-004 SHALL have parameter WD_ERR_INFO, default 4: error info width, minimum 2.
REQ-005 SHALL have port i_sys_clk  input  1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port i_sys_rst  input  1: reset, synchronous, active-high.
REQ-007 SHALL have port s_shk_reg_valid  input  1: request strobe, one-cycle pulse.
REQ-008 SHALL have port s_shk_reg_msync  input  1: sync/clear strobe.
REQ-009 SHALL have port s_shk_reg_mdata  input  WD_SHK_DATA: write data.
REQ-010 SHALL have port s_shk_reg_maddr  input  WD_SHK_ADDR: bit [MSB] 1 = write, 0 = read; low log2(NB_REG_DEPTH) bits = index.
REQ-011 SHALL have port s_shk_reg_ready  output  1: response strobe.
REQ-012 SHALL have port s_shk_reg_ssync  output  1: sync acknowledge.
REQ-013 SHALL have port s_shk_reg_sdata  output  WD_SHK_DATA: read data, or written data echoed on writes.
REQ-014 SHALL have port s_shk_reg_saddr  output  WD_SHK_ADDR: captured request address, echoed.
REQ-015 SHALL have port m_err_reg_info1  output  WD_ERR_INFO: error status.

Function
REQ-016 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; leave IDLE only on valid=1.
- IDLE with valid=1: capture maddr/mdata and go to ACCESS.
- ACCESS: a write stores mdata at the index; a read loads the register into the sdata register; always go to RESP.
- RESP: ready=1 for exactly one cycle, then return to IDLE.
REQ-017 SHALL assert ready exactly 2 cycles after the valid cycle (valid at edge N, ready high during the cycle after edge N+2), for exactly 1 cycle.
REQ-018 SHALL hold sdata/saddr stable from ready until the next response's ready.
REQ-019 SHALL treat any maddr bit between the index field and the MSB being nonzero as an address error.
- No register is written; sdata = 0; ready is still returned.
- Error bit 0 is set.
REQ-020 SHALL drop any valid=1 seen in ACCESS or RESP: no response, no state change, error bit 1 set (overrun).
REQ-021 SHALL, on msync=1 in any state, pulse ssync=1 on the following cycle only, clear all registers to 0, and clear error bits 0 and 1.
REQ-022 SHALL, when valid and msync arrive in the same cycle in IDLE, apply the clear first and then process the request normally, so a write lands on the cleared bank.
REQ-023 SHALL, when msync arrives during ACCESS, let a write in that same ACCESS cycle take precedence over the clear for that index only; the response still completes.
REQ-024 SHALL keep error bits 0 and 1 sticky until msync or reset; bits [WD_ERR_INFO-1:2] SHALL read 0 unless REQ-030 applies.

Reset
REQ-025 SHALL, on i_sys_rst=1 at a clock edge, enter IDLE and clear all registers, ready, ssync, sdata, saddr and m_err_reg_info1 to 0.
REQ-026 SHALL, on reset during ACCESS or RESP, abort the transaction: no ready and no write.
REQ-027 SHALL ignore valid while i_sys_rst=1.

Configuration
REQ-028 SHALL compile the error counter only when macro SHK_REG_ERR_CNT_EN is defined.
REQ-029 SHALL, without SHK_REG_ERR_CNT_EN, hold m_err_reg_info1[WD_ERR_INFO-1:2] at 0 and infer no counter.
REQ-030 SHALL, with SHK_REG_ERR_CNT_EN, count address and overrun errors in m_err_reg_info1[WD_ERR_INFO-1:2]:
- Counts +1 per error event, saturating at all ones.
- Two events in one cycle count +2, saturating.
- Cleared by msync or reset.

Verification
REQ-031 SHALL cover a write then a read: valid maddr=0x8003 mdata=0xA5A5 -> ready 2 cycles later with saddr=0x8003, sdata=0xA5A5; then maddr=0x0003 -> sdata=0xA5A5.
REQ-032 SHALL cover a bad address: valid maddr=0x0013 (NB_REG_DEPTH=16) -> ready, sdata=0, info[0]=1, register bank unchanged.
REQ-033 SHALL cover overrun: valid at cycles N and N+1 -> a single ready at N+2, info[1]=1; with macro defined, info[3:2]=1.
REQ-034 SHALL cover clear: write 0x1234 at index 5, pulse msync -> ssync 1 cycle later, info=0, read of index 5 returns 0.
REQ-035 SHALL cover simultaneous valid+msync writing 0x0F0F at index 2 -> index 2=0x0F0F, all other registers 0.
REQ-036 SHALL cover reset mid-operation: assert i_sys_rst in ACCESS of a write -> no ready, target register reads 0 after reset.
